// File: rtl/alu_input_sequencer.sv
// rtl/alu_input_sequencer.sv - debounced three-button operand/opcode entry sequencer for an ALU
// Buttons are synchronized, debounced and edge-detected, then drive a SEL_OP/LOAD_A/LOAD_B/SHOW FSM.
module alu_input_sequencer #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_prev,
  input  logic         btn_enter,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   control,
  output logic         alu_valid,
  output logic [1:0]   state
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_ENTER = 2;

  typedef enum logic [1:0] {
    SEL_OP = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    SHOW   = 2'd3
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_lvl;
  logic [2:0]    r_evt;
  logic [CW-1:0] r_cnt [3];

  assign w_raw = {btn_enter, btn_prev, btn_next};

  // The press pulse is raised on the same edge the accepted level falls, so the FSM
  // acts on it one cycle later: 2 sync + DEB_CYCLES qualify + 1 register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_lvl   <= 3'b111;
      r_evt   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_evt   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i] <= '0;
          r_lvl[i] <= r_sync2[i];
          r_evt[i] <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_control;
  logic [3:0]   w_control_nxt;
  logic [N-1:0] r_a;
  logic [N-1:0] w_a_nxt;
  logic [N-1:0] r_b;
  logic [N-1:0] w_b_nxt;
  logic         r_valid;
  logic         w_valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEL_OP;
      r_control <= 4'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_control <= w_control_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // Enter wins over next, next wins over prev; losers in the same cycle are dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_control_nxt = r_control;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_valid_nxt   = r_valid;
    case (r_state)
      SEL_OP: begin
        w_valid_nxt = 1'b0;
        if (r_evt[BTN_ENTER]) begin
          w_state_nxt = LOAD_A;
        end else if (r_evt[BTN_NEXT]) begin
          w_control_nxt = (r_control >= 4'd9) ? 4'd0 : r_control + 4'd1;
        end else if (r_evt[BTN_PREV]) begin
          w_control_nxt = (r_control == 4'd0 || r_control > 4'd9) ? 4'd9 : r_control - 4'd1;
        end
      end
      LOAD_A: begin
        w_valid_nxt = 1'b0;
        if (r_evt[BTN_ENTER]) begin
          w_a_nxt     = sw;
          w_state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        w_valid_nxt = 1'b0;
        if (r_evt[BTN_ENTER]) begin
          w_b_nxt     = sw;
          w_valid_nxt = 1'b1;
          w_state_nxt = SHOW;
        end
      end
      SHOW: begin
        w_valid_nxt = 1'b1;
        if (r_evt[BTN_ENTER]) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = SEL_OP;
        end
      end
      default: begin
        w_state_nxt = SEL_OP;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign a         = r_a;
  assign b         = r_b;
  assign control   = r_control;
  assign alu_valid = r_valid;
  assign state     = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb/tb_alu_input_sequencer.sv - randomized and directed bench for alu_input_sequencer
// Reference model works from raw-sample history windows and modulo-10 opcode arithmetic.
module tb_alu_input_sequencer;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic         btn_next;
  logic         btn_prev;
  logic         btn_enter;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   control;
  logic         alu_valid;
  logic [1:0]   state;

  alu_input_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .btn_enter (btn_enter),
    .a         (a),
    .b         (b),
    .control   (control),
    .alu_valid (alu_valid),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: raw[0]=next, raw[1]=prev, raw[2]=enter (active low)
  int m_state, m_ctrl, m_a, m_b, m_valid;
  bit m_lvl  [3];
  bit m_pend [3];
  bit rq [3][$];
  bit dq [3][$];

  function automatic void model_reset();
    m_state = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_valid = 0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i]  = 1'b1;
      m_pend[i] = 1'b0;
      rq[i]     = {1'b1, 1'b1};
      dq[i]     = {};
    end
  endfunction

  function automatic void model_edge(input bit [2:0] raw, input int swv);
    bit din, all_diff;
    if (m_pend[2]) begin
      case (m_state)
        0: m_state = 1;
        1: begin m_a = swv; m_state = 2; end
        2: begin m_b = swv; m_state = 3; m_valid = 1; end
        default: begin m_valid = 0; m_state = 0; end
      endcase
    end else if (m_state == 0 && m_pend[0]) begin
      m_ctrl = (m_ctrl + 1) % 10;
    end else if (m_state == 0 && m_pend[1]) begin
      m_ctrl = (m_ctrl + 9) % 10;
    end
    // A button reaches the debouncer two samples late; it is accepted once the
    // last DEB debouncer samples all disagree with the accepted level.
    for (int i = 0; i < 3; i++) begin
      rq[i].push_back(raw[i]);
      din = rq[i][rq[i].size() - 3];
      if (rq[i].size() > 4) void'(rq[i].pop_front());
      dq[i].push_back(din);
      if (dq[i].size() > DEB) void'(dq[i].pop_front());
      m_pend[i] = 1'b0;
      all_diff  = (dq[i].size() == DEB);
      foreach (dq[i][k]) if (dq[i][k] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[i]  = ~m_lvl[i];
        m_pend[i] = (m_lvl[i] == 1'b0);
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("state",     state,     m_state);
    check_eq("control",   control,   m_ctrl);
    check_eq("a",         a,         m_a);
    check_eq("b",         b,         m_b);
    check_eq("alu_valid", alu_valid, m_valid);
  endtask

  task automatic cycle(input bit [2:0] raw, input logic [N-1:0] swv);
    btn_next  = raw[0];
    btn_prev  = raw[1];
    btn_enter = raw[2];
    sw        = swv;
    @(posedge clk);
    model_edge(raw, int'(swv));
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic [N-1:0] swv);
    repeat (n) cycle(3'b111, swv);
  endtask

  task automatic press(input bit [2:0] mask, input int hold, input logic [N-1:0] swv);
    repeat (hold) cycle(~mask, swv);
    idle(DEB + 6, swv);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, state,     0);
    check_eq({tag, "_ctrl"},  control,   0);
    check_eq({tag, "_a"},     a,         0);
    check_eq({tag, "_b"},     b,         0);
    check_eq({tag, "_valid"}, alu_valid, 0);
  endtask

  // Called 1 time unit after a rising edge; asserts rst well before the next edge.
  task automatic async_reset(input bit [2:0] raw);
    btn_next  = raw[0];
    btn_prev  = raw[1];
    btn_enter = raw[2];
    #3 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    #1 check_reset_values("rst_held");
    rst = 1'b0;
    model_reset();
  endtask

  bit [2:0] r_raw;
  int       saved_ctrl;

  initial begin
    rst = 1'b1; sw = '0; btn_next = 1'b1; btn_prev = 1'b1; btn_enter = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values("init");
    rst = 1'b0;

    // Single next press: exact latency and no release event
    for (int k = 1; k <= 20; k++) begin
      cycle(3'b110, 4'h0);
      if (k == 6) check_eq("lat_before", control, 0);
      if (k == 7) check_eq("lat_at", control, 1);
    end
    idle(20, 4'h0);
    check_eq("one_event", control, 1);

    // Wrap forward 9->0 and backward 0->9
    repeat (8) press(3'b001, 6, 4'h0);
    check_eq("at_nine", control, 9);
    press(3'b001, 6, 4'h0);
    check_eq("wrap_up", control, 0);
    press(3'b010, 6, 4'h0);
    check_eq("wrap_down", control, 9);

    // Short glitches never qualify
    saved_ctrl = m_ctrl;
    repeat (8) begin
      repeat (3) cycle(3'b110, 4'h0);
      repeat (3) cycle(3'b111, 4'h0);
    end
    idle(10, 4'h0);
    check_eq("glitch", control, saved_ctrl);

    // Full operand entry sequence
    async_reset(3'b111);
    repeat (3) press(3'b001, 6, 4'h0);
    press(3'b100, 6, 4'h0);
    press(3'b100, 6, 4'hA);
    press(3'b100, 6, 4'h5);
    check_eq("seq_a", a, 4'hA);
    check_eq("seq_b", b, 4'h5);
    check_eq("seq_ctrl", control, 3);
    check_eq("seq_valid", alu_valid, 1);
    check_eq("seq_state", state, 3);
    idle(10, 4'h0);
    check_eq("sw_ignored_a", a, 4'hA);
    check_eq("sw_ignored_b", b, 4'h5);
    press(3'b100, 6, 4'h0);
    check_eq("show_exit_valid", alu_valid, 0);
    check_eq("show_exit_state", state, 0);

    // Enter beats simultaneous next; next ignored outside SEL_OP
    press(3'b101, 6, 4'h3);
    check_eq("simul_state", state, 1);
    check_eq("simul_ctrl", control, 3);
    press(3'b100, 6, 4'h7);
    press(3'b001, 6, 4'h7);
    check_eq("loadb_next_ctrl", control, 3);
    check_eq("loadb_state", state, 2);

    // Reset in SHOW with next held: re-qualified from zero after release
    press(3'b100, 6, 4'h9);
    check_eq("show_state", state, 3);
    repeat (3) cycle(3'b110, 4'h1);
    async_reset(3'b110);
    for (int k = 1; k <= DEB + 3; k++) begin
      cycle(3'b110, 4'h1);
      if (k == DEB + 2) check_eq("post_rst_before", control, 0);
      if (k == DEB + 3) check_eq("post_rst_at", control, 1);
    end
    idle(12, 4'h1);

    // Randomized button chatter with occasional resets
    r_raw = 3'b111;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) r_raw[i] = ~r_raw[i];
      if (c % 1000 == 999) async_reset(r_raw);
      else cycle(r_raw, N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter: N, default 4, operand width in bits.
REQ-002 Parameter: DEB_CYCLES, default 500000, consecutive stable synchronized samples required to accept a new button level.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: sw  input  N  raw operand switches.
REQ-006 Port: btn_next  input  1  raw button, active-low (idle 1); a press increments the operation code.
REQ-007 Port: btn_prev  input  1  raw button, active-low; a press decrements the operation code.
REQ-008 Port: btn_enter  input  1  raw button, active-low; a press advances the sequence.
REQ-009 Port: a  output  N  registered operand A to the ALU.
REQ-010 Port: b  output  N  registered operand B to the ALU.
REQ-011 Port: control  output  4  registered ALU operation code, range 0..9.
REQ-012 Port: alu_valid  output  1  high while a, b and control form a committed operation.
REQ-013 Port: state  output  2  current FSM state encoding: SEL_OP=0, LOAD_A=1, LOAD_B=2, SHOW=3.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-015 Debouncer: per button, counter cleared whenever the synchronized sample equals the accepted level; accepted level SHALL flip only after DEB_CYCLES consecutive differing samples.
REQ-016 Press event SHALL be a one-cycle pulse on a 1->0 transition of the accepted level; release (0->1) SHALL generate no event.
REQ-017 Glitches shorter than DEB_CYCLES cycles SHALL produce no event.
REQ-018 Event latency SHALL be exactly 2 + DEB_CYCLES + 1 cycles from a clean raw falling edge to the resulting register update.
REQ-019 SEL_OP: next event -> control = (control == 9) ? 0 : control+1; prev event -> control = (control == 0) ? 9 : control-1.
REQ-020 SEL_OP: enter event -> LOAD_A; control unchanged.
REQ-021 LOAD_A: enter event -> a <= sw, go to LOAD_B.
REQ-022 LOAD_B: enter event -> b <= sw, go to SHOW; alu_valid SHALL assert on the same edge.
REQ-023 SHOW: alu_valid held 1; enter event -> alu_valid <= 0, go to SEL_OP; a, b, control retained.
REQ-024 alu_valid SHALL be 0 in SEL_OP, LOAD_A, LOAD_B.
REQ-025 next/prev events outside SEL_OP SHALL be ignored.
REQ-026 Simultaneous events in one cycle: enter has priority over next and prev; next has priority over prev; lower-priority events that cycle SHALL be discarded, not queued.
REQ-027 a and b SHALL change only at REQ-021/REQ-022 edges; sw changes at other times SHALL have no effect.
REQ-028 control SHALL never hold a value above 9.

Reset
REQ-029 rst high SHALL immediately (without clk) force: state=SEL_OP, control=0, a=0, b=0, alu_valid=0, synchronizer flops=1, accepted levels=1, debounce counters=0, event pulses=0.
REQ-030 Reset mid-sequence (any state, any debounce count) SHALL discard all pending progress; a press in progress during reset SHALL be re-qualified from zero after release of rst.
REQ-031 First rising clk edge after rst deassertion SHALL operate normally with no spurious event.

Verification (DEB_CYCLES=4, N=4)
REQ-032 Reset, hold btn_next low 20 cycles, release -> exactly one event; control 0->1 at cycle 7 after the raw edge; no event on release.
REQ-033 From control=9, one next press -> control=0; from control=0, one prev press -> control=9.
REQ-034 btn_next low pulses of 3 cycles repeated -> control unchanged, no events.
REQ-035 control=3; enter; sw=4'hA, enter; sw=4'h5, enter -> a=A, b=5, control=3, alu_valid=1, state=3; change sw to 0 -> a, b unchanged; enter -> alu_valid=0, state=0.
REQ-036 btn_enter and btn_next fall on same cycle in SEL_OP -> state=LOAD_A, control unchanged; next pressed in LOAD_B -> control unchanged.
REQ-037 Assert rst asynchronously in SHOW mid-clock -> outputs reach reset values before next clk edge; held button during rst yields its event only after DEB_CYCLES+3 cycles post-release of rst.
